mem_responder: RTL and testbench

- Memory-side target serving the CPU control unit's byte-addressed memory accesses.
- Owns a 16-bit-wide word RAM.
- Accepts word and byte read/write requests through a valid/ready handshake.
- Performs byte-lane read-modify-write internally, so the initiator no longer merges lanes.
- A word-wide loader port pre-loads program images and has priority over CPU requests.

---
 rtl/mem_responder.sv | 179 +++++++++++++++++
 tb/tb_mem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side target for the CPU control unit.
// Owns a 16-bit word RAM, serves word/byte reads and writes over a
// valid/ready handshake and merges byte writes internally (read-modify-write).
// A word-wide loader port has priority over CPU requests while idle.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a loader write or a CPU request
// RD     | registered read of the addressed word into the response
// WR     | full-word write of the latched data
// RMW_RD | byte write, step 1: capture the current word in the hold register
// RMW_WR | byte write, step 2: write the merged word back
// RESP   | one-cycle response pulse, then back to IDLE
module mem_responder #(
    parameter int    DEPTH     = 128,
    parameter int    AW        = 8,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic          req_byte,
    input  logic [AW-1:0] req_addr,
    input  logic [15:0]   req_wdata,
    output logic          rsp_valid,
    output logic [15:0]   rsp_rdata,
    output logic          rsp_err,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-2:0] ld_addr,
    input  logic [15:0]   ld_data
);

    // Word-index width; upper byte-address bits beyond it are ignored,
    // so the index wraps modulo DEPTH.
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

    state_t state;
    state_t state_nx;

    logic [15:0]   mem [DEPTH];

    logic          lat_byte;
    logic [AW-1:0] lat_addr;
    logic [15:0]   lat_wdata;
    logic [15:0]   hold;

    logic          accept;
    logic          misaligned;
    logic [IW-1:0] idx;
    logic [15:0]   rd_word;
    logic [7:0]    lane;
    logic [15:0]   merged;

    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;

    assign ld_ready   = (state == IDLE) & ~rst;
    assign req_ready  = (state == IDLE) & ~ld_valid & ~rst;
    assign accept     = req_valid & req_ready;
    assign misaligned = ~req_byte & req_addr[0];
    assign rsp_valid  = (state == RESP);

    assign idx     = lat_addr[IW:1];
    assign rd_word = mem[idx];
    assign lane    = lat_addr[0] ? rd_word[15:8] : rd_word[7:0];
    // The addressed lane takes the new byte; the other lane comes from hold.
    assign merged  = lat_addr[0] ? {lat_wdata[7:0], hold[7:0]}
                                 : {hold[15:8], lat_wdata[7:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; the request type is resolved once at accept.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)      state_nx = RESP;
                    else if (!req_we)    state_nx = RD;
                    else if (!req_byte)  state_nx = WR;
                    else                 state_nx = RMW_RD;
                end
            end
            RD:      state_nx = RESP;
            WR:      state_nx = RESP;
            RMW_RD:  state_nx = RMW_WR;
            RMW_WR:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // RAM write port select; reset blocks every write, including a pending RMW.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = lat_wdata;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        mem_we    = 1'b1;
                        mem_waddr = ld_addr[IW-1:0];
                        mem_wdata = ld_data;
                    end
                end
                WR: begin
                    mem_we = 1'b1;
                end
                RMW_WR: begin
                    mem_we    = 1'b1;
                    mem_wdata = merged;
                end
                default: ;
            endcase
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Request latch, RMW hold register and response data/error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_byte  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            hold      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_byte  <= req_byte;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                if (misaligned) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
            case (state)
                RD: begin
                    rsp_rdata <= lat_byte ? {8'h00, lane} : rd_word;
                    rsp_err   <= 1'b0;
                end
                WR: begin
                    rsp_rdata <= lat_wdata;
                    rsp_err   <= 1'b0;
                end
                RMW_RD: begin
                    hold <= rd_word;
                end
                RMW_WR: begin
                    rsp_rdata <= merged;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus against mem_responder with a
// transaction-level model (memory array + latency bookkeeping) checked
// every cycle, plus literal expectations on each directed request.
module tb_mem_responder;

    localparam int DEPTH = 128;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic          req_byte = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [15:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [15:0]   rsp_rdata;
    logic          rsp_err;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-2:0] ld_addr = '0;
    logic [15:0]   ld_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    mem_responder #(.DEPTH(DEPTH), .AW(AW), .INIT_FILE("")) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Each accepted request finishes a fixed number of edges later
    // (error 1, read 2, word write 2, byte write 3); the RAM update and
    // response happen on that last edge unless a reset edge comes first.
    logic [15:0] mmem [DEPTH];
    int          cyc      = 0;
    int          busy_end = -1;
    bit          chk_en   = 0;
    bit          pend     = 0;
    int          pend_edge;
    bit          pend_wr;
    int          pend_idx;
    logic [15:0] pend_data;
    logic [15:0] pend_rd;
    logic [15:0] m_rdata = '0;
    bit          m_err   = 0;
    bit          m_valid = 0;

    // Model update on every active edge from the inputs held during the cycle.
    always @(posedge clk) begin : model
        int          k;
        int          lat;
        int          wi;
        bit          was_idle;
        logic [15:0] w;
        logic [7:0]  ln;
        was_idle = (cyc > busy_end);
        k        = cyc + 1;
        cyc      = k;
        m_valid  = 0;
        if (rst) begin
            pend     = 0;
            m_rdata  = '0;
            m_err    = 0;
            busy_end = k - 1;
            chk_en   = 1;
        end else if (pend && k == pend_edge) begin
            if (pend_wr) mmem[pend_idx] = pend_data;
            m_rdata = pend_rd;
            m_err   = 0;
            m_valid = 1;
            pend    = 0;
        end else if (was_idle) begin
            if (ld_valid) begin
                mmem[int'(ld_addr) % DEPTH] = ld_data;
            end else if (req_valid) begin
                wi = (int'(req_addr) / 2) % DEPTH;
                if (!req_byte && req_addr[0]) begin
                    m_rdata  = '0;
                    m_err    = 1;
                    m_valid  = 1;
                    busy_end = k;
                end else begin
                    w  = mmem[wi];
                    ln = req_addr[0] ? w[15:8] : w[7:0];
                    pend_idx = wi;
                    if (!req_we) begin
                        pend_wr = 0;
                        pend_rd = req_byte ? {8'h00, ln} : w;
                        lat     = 2;
                    end else if (!req_byte) begin
                        pend_wr   = 1;
                        pend_data = req_wdata;
                        pend_rd   = req_wdata;
                        lat       = 2;
                    end else begin
                        pend_wr   = 1;
                        pend_data = req_addr[0] ? {req_wdata[7:0], w[7:0]}
                                                : {w[15:8], req_wdata[7:0]};
                        pend_rd   = pend_data;
                        lat       = 3;
                    end
                    pend      = 1;
                    pend_edge = k + lat - 1;
                    busy_end  = pend_edge;
                end
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin : compare
        bit exp_ld;
        bit exp_req;
        if (chk_en) begin
            exp_ld  = (cyc > busy_end) && !rst;
            exp_req = exp_ld && !ld_valid;
            chk("mdl_ld_ready", {31'd0, ld_ready}, {31'd0, exp_ld});
            chk("mdl_req_ready", {31'd0, req_ready}, {31'd0, exp_req});
            chk("mdl_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
            chk("mdl_rsp_rdata", {16'd0, rsp_rdata}, {16'd0, m_rdata});
            chk("mdl_rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
        end
    end

    // Issue one request starting just after a negedge, wait for accept and
    // response (both bounded), and check literal expectations.
    task automatic issue(input bit we, input bit bt, input logic [AW-1:0] addr,
                         input logic [15:0] wd, input logic [15:0] exp_rd,
                         input bit exp_err, input int exp_lat, input string nm,
                         output int waits);
        bit acc;
        bit got;
        int lat;
        acc   = 0;
        got   = 0;
        waits = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = bt;
        req_addr  = addr;
        req_wdata = wd;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            if (req_ready) begin
                acc = 1;
                @(posedge clk);
            end else begin
                waits++;
                @(negedge clk);
            end
        end
        if (!acc) begin
            chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 8 && !got; i++) begin
            if (rsp_valid) got = 1;
            else begin
                lat++;
                @(negedge clk);
            end
        end
        if (!got) begin
            chk({nm, "_rsp_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_rd});
        chk({nm, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          w;
        int          nacc;
        int          last;
        logic [AW-1:0] b2b [3];

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);

        // Word write then read.
        issue(1, 0, 8'h10, 16'hBEEF, 16'hBEEF, 0, 2, "wr_10", w);
        issue(0, 0, 8'h10, 16'h0000, 16'hBEEF, 0, 2, "rd_10", w);

        // Byte RMW keeps the other lane; upper wdata bits ignored.
        issue(1, 0, 8'h20, 16'h1234, 16'h1234, 0, 2, "wr_20", w);
        issue(1, 1, 8'h21, 16'h00AB, 16'hAB34, 0, 3, "bw_21", w);
        issue(0, 0, 8'h20, 16'h0000, 16'hAB34, 0, 2, "rd_20", w);
        issue(0, 1, 8'h20, 16'h0000, 16'h0034, 0, 2, "br_20", w);
        issue(0, 1, 8'h21, 16'h0000, 16'h00AB, 0, 2, "br_21", w);
        issue(1, 1, 8'h20, 16'hFFCD, 16'hABCD, 0, 3, "bw_20", w);

        // Misaligned word accesses leave RAM untouched.
        issue(1, 0, 8'h06, 16'h1111, 16'h1111, 0, 2, "wr_06", w);
        issue(1, 0, 8'h07, 16'hFFFF, 16'h0000, 1, 1, "mis_wr_07", w);
        issue(0, 0, 8'h06, 16'h0000, 16'h1111, 0, 2, "rd_06", w);
        issue(0, 0, 8'h0B, 16'h0000, 16'h0000, 1, 1, "mis_rd_0b", w);

        // Loader priority over a simultaneous CPU read.
        @(negedge clk);
        ld_valid  = 1'b1;
        ld_addr   = 7'd3;
        ld_data   = 16'h5A5A;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 8'h06;
        #1;
        chk("prio_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("prio_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        issue(0, 0, 8'h06, 16'h0000, 16'h5A5A, 0, 2, "prio_rd_06", w);
        chk("prio_accept_waits", w, 32'd0);

        // Loader burst on consecutive cycles, read back.
        @(negedge clk);
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_addr = 7'h50 + 7'(i);
            ld_data = 16'hC000 + 16'(i);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        issue(0, 0, 8'hA0, 16'h0000, 16'hC000, 0, 2, "ld_rd_50", w);
        issue(0, 0, 8'hA4, 16'h0000, 16'hC002, 0, 2, "ld_rd_52", w);

        // Reset during RMW_WR suppresses the write and the response.
        issue(1, 0, 8'h40, 16'h00FF, 16'h00FF, 0, 2, "wr_40", w);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b1;
        req_addr  = 8'h41;
        req_wdata = 16'h0011;
        #1;
        chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rmw_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rmw_rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        issue(0, 0, 8'h40, 16'h0000, 16'h00FF, 0, 2, "rd_40", w);

        // Back-to-back reads with req_valid held high.
        b2b[0] = 8'h10;
        b2b[1] = 8'h20;
        b2b[2] = 8'h06;
        @(negedge clk);
        nacc = 0;
        last = -1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = b2b[0];
        for (int c = 0; c < 30 && nacc < 3; c++) begin
            #1;
            chk("b2b_no_overlap", {31'd0, req_ready & rsp_valid}, 32'd0);
            if (req_ready) begin
                if (last >= 0) chk("b2b_spacing", c - last, 32'd3);
                last = c;
                nacc++;
            end
            @(negedge clk);
            if (nacc < 3) req_addr = b2b[nacc];
        end
        req_valid = 1'b0;
        chk("b2b_accepts", nacc, 32'd3);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
